// File: rtl/i2s_xfer_sched.sv
// -----------------------------------------------------------------------------
// i2s_xfer_sched
// Transfer scheduler between the APB register side and the I2S Tx/Rx FIFOs.
// Everything runs on pclk. One Tx word and one Rx word are held locally.
// Tx pushes and Rx prefetch pops share a single FIFO access slot per cycle.
// When both want that slot in the same cycle, the side that did not win the
// last contested cycle gets it. On stop, an unpaired stereo frame is padded
// with a zero right word before the block returns to IDLE.
//
// Ports
//   pclk, rst_          clock, asynchronous active-low reset
//   mode[1:0]           SR=00, ST=01, MR=10, MT=11 (Tx: ST/MT, Rx: SR/MR)
//   stop, mute, stereo  level controls
//   soft_rst            synchronous clear of all state (highest priority)
//   flag_clr            pulse, clears tx_ovr / rx_udr
//   tx_req, tx_wdata    APB write of the Tx data register
//   rx_req              APB read of the Rx data register
//   tx_full, rx_empty   FIFO status
//   rx_fifo_dout        Rx FIFO head word, sampled at the end of the rx_ren cycle
//   tx_wen, tx_fifo_din Tx FIFO write strobe / data (registered)
//   rx_ren              Rx FIFO read strobe (registered)
//   rx_rdata, rx_valid  Rx holding register and its unread flag
//   tx_busy             Tx holding register occupied
//   tx_ovr, rx_udr      sticky error flags
//   ch_r                next stereo Tx push is the right channel
//   state               IDLE=00, RUN=01, DRAIN=10
// -----------------------------------------------------------------------------
module i2s_xfer_sched (
   input  logic        pclk,
   input  logic        rst_,
   input  logic [1:0]  mode,
   input  logic        stop,
   input  logic        mute,
   input  logic        stereo,
   input  logic        soft_rst,
   input  logic        flag_clr,
   input  logic        tx_req,
   input  logic [31:0] tx_wdata,
   input  logic        rx_req,
   input  logic        tx_full,
   input  logic        rx_empty,
   input  logic [31:0] rx_fifo_dout,
   output logic        tx_wen,
   output logic [31:0] tx_fifo_din,
   output logic        rx_ren,
   output logic [31:0] rx_rdata,
   output logic        tx_busy,
   output logic        rx_valid,
   output logic        tx_ovr,
   output logic        rx_udr,
   output logic        ch_r,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t      state_q,     state_d;
   logic [31:0] tx_hold_q,   tx_hold_d;
   logic        tx_busy_q,   tx_busy_d;
   logic        tx_wen_q,    tx_wen_d;
   logic [31:0] tx_din_q,    tx_din_d;
   logic        rx_ren_q,    rx_ren_d;
   logic [31:0] rx_rdata_q,  rx_rdata_d;
   logic        rx_valid_q,  rx_valid_d;
   logic        tx_ovr_q,    tx_ovr_d;
   logic        rx_udr_q,    rx_udr_d;
   logic        ch_r_q,      ch_r_d;
   logic        rr_rx_q,     rr_rx_d;   // 1: Rx wins the next contested cycle

   logic tx_mode_s, rx_mode_s;
   logic idle_s, run_s, drain_s;
   logic tx_elig_s, pad_elig_s, rx_elig_s, contest_s;
   logic tx_gnt_s, rx_gnt_s, push_s;
   logic tx_acc_s, tx_drop_s, rx_take_s, rx_miss_s;

   // Slot arbitration and request classification for the current cycle
   always_comb begin
      tx_mode_s  = (mode == 2'b01) || (mode == 2'b11);
      rx_mode_s  = (mode == 2'b00) || (mode == 2'b10);
      idle_s     = (state_q == ST_IDLE);
      run_s      = (state_q == ST_RUN);
      drain_s    = (state_q == ST_DRAIN);

      tx_elig_s  = !idle_s && tx_busy_q && !tx_full;
      // Pad only once the real word is gone and a left sample is unpaired
      pad_elig_s = drain_s && !tx_busy_q && stereo && ch_r_q && !tx_full;
      // rx_ren_q doubles as the "read in flight" marker: capture is next edge
      rx_elig_s  = run_s && rx_mode_s && !rx_valid_q && !rx_ren_q && !rx_empty;
      contest_s  = tx_elig_s && rx_elig_s;

      tx_gnt_s   = tx_elig_s && (!rx_elig_s || !rr_rx_q);
      rx_gnt_s   = rx_elig_s && (!tx_elig_s || rr_rx_q);
      // Pad is DRAIN-only, where Rx is never eligible, so it needs no arbitration
      push_s     = tx_gnt_s || pad_elig_s;

      // A push in the same cycle frees the hold register for the new word
      tx_acc_s   = tx_req && run_s && tx_mode_s && (!tx_busy_q || tx_gnt_s);
      tx_drop_s  = tx_req && ((run_s && !tx_acc_s) || drain_s);
      rx_take_s  = rx_req && !idle_s && rx_valid_q;
      rx_miss_s  = rx_req && !idle_s && !rx_valid_q;
   end

   // Next-state values for the FSM, data path and flags
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!stop) state_d = ST_RUN;
            else       state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (stop) state_d = ST_DRAIN;
            else      state_d = ST_RUN;
         end
         ST_DRAIN: begin
            if (!tx_busy_q && !(stereo && ch_r_q)) state_d = ST_IDLE;
            else                                    state_d = ST_DRAIN;
         end
         default: state_d = ST_IDLE;
      endcase

      tx_hold_d = tx_acc_s ? tx_wdata : tx_hold_q;
      if (tx_acc_s)      tx_busy_d = 1'b1;
      else if (tx_gnt_s) tx_busy_d = 1'b0;
      else               tx_busy_d = tx_busy_q;

      tx_wen_d = push_s;
      if (tx_gnt_s)        tx_din_d = mute ? 32'h0 : tx_hold_q;
      else if (pad_elig_s) tx_din_d = 32'h0;
      else                 tx_din_d = tx_din_q;

      ch_r_d = (push_s && stereo) ? !ch_r_q : ch_r_q;

      rx_ren_d   = rx_gnt_s;
      rx_rdata_d = rx_ren_q ? rx_fifo_dout : rx_rdata_q;
      if (rx_ren_q)       rx_valid_d = 1'b1;
      else if (rx_take_s) rx_valid_d = 1'b0;
      else                rx_valid_d = rx_valid_q;

      // Set events win over a same-cycle flag_clr
      if (tx_drop_s)     tx_ovr_d = 1'b1;
      else if (flag_clr) tx_ovr_d = 1'b0;
      else               tx_ovr_d = tx_ovr_q;
      if (rx_miss_s)     rx_udr_d = 1'b1;
      else if (flag_clr) rx_udr_d = 1'b0;
      else               rx_udr_d = rx_udr_q;

      rr_rx_d = contest_s ? !rr_rx_q : rr_rx_q;
   end

   // State register: async reset, soft reset, otherwise load next state
   always_ff @(posedge pclk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= ST_IDLE;
         tx_hold_q  <= 32'h0;
         tx_busy_q  <= 1'b0;
         tx_wen_q   <= 1'b0;
         tx_din_q   <= 32'h0;
         rx_ren_q   <= 1'b0;
         rx_rdata_q <= 32'h0;
         rx_valid_q <= 1'b0;
         tx_ovr_q   <= 1'b0;
         rx_udr_q   <= 1'b0;
         ch_r_q     <= 1'b0;
         rr_rx_q    <= 1'b0;
      end else if (soft_rst) begin
         state_q    <= ST_IDLE;
         tx_hold_q  <= 32'h0;
         tx_busy_q  <= 1'b0;
         tx_wen_q   <= 1'b0;
         tx_din_q   <= 32'h0;
         rx_ren_q   <= 1'b0;
         rx_rdata_q <= 32'h0;
         rx_valid_q <= 1'b0;
         tx_ovr_q   <= 1'b0;
         rx_udr_q   <= 1'b0;
         ch_r_q     <= 1'b0;
         rr_rx_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_hold_q  <= tx_hold_d;
         tx_busy_q  <= tx_busy_d;
         tx_wen_q   <= tx_wen_d;
         tx_din_q   <= tx_din_d;
         rx_ren_q   <= rx_ren_d;
         rx_rdata_q <= rx_rdata_d;
         rx_valid_q <= rx_valid_d;
         tx_ovr_q   <= tx_ovr_d;
         rx_udr_q   <= rx_udr_d;
         ch_r_q     <= ch_r_d;
         rr_rx_q    <= rr_rx_d;
      end
   end

   assign tx_wen      = tx_wen_q;
   assign tx_fifo_din = tx_din_q;
   assign rx_ren      = rx_ren_q;
   assign rx_rdata    = rx_rdata_q;
   assign tx_busy     = tx_busy_q;
   assign rx_valid    = rx_valid_q;
   assign tx_ovr      = tx_ovr_q;
   assign rx_udr      = rx_udr_q;
   assign ch_r        = ch_r_q;
   assign state       = state_q;

endmodule

// File: tb/tb_i2s_xfer_sched.sv
// Testbench for i2s_xfer_sched: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_i2s_xfer_sched;

   logic        pclk = 1'b0;
   logic        rst_;
   logic [1:0]  mode;
   logic        stop, mute, stereo, soft_rst, flag_clr;
   logic        tx_req, rx_req, tx_full, rx_empty;
   logic [31:0] tx_wdata, rx_fifo_dout;
   logic        tx_wen, rx_ren, tx_busy, rx_valid, tx_ovr, rx_udr, ch_r;
   logic [31:0] tx_fifo_din, rx_rdata;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase 0 idle / 1 run / 2 drain
   int          m_phase;
   logic [31:0] m_hold[$];
   bit          m_odd;       // odd number of stereo pushes so far
   bit          m_inflight;
   bit          m_have;
   logic [31:0] m_rx_word;
   bit          m_ovr, m_udr;
   int          m_turn;      // 0: Tx wins next contest, 1: Rx wins
   bit          e_wen, e_ren;
   logic [31:0] e_din;

   always #5 pclk = ~pclk;

   i2s_xfer_sched dut (
      .pclk(pclk), .rst_(rst_), .mode(mode), .stop(stop), .mute(mute),
      .stereo(stereo), .soft_rst(soft_rst), .flag_clr(flag_clr),
      .tx_req(tx_req), .tx_wdata(tx_wdata), .rx_req(rx_req),
      .tx_full(tx_full), .rx_empty(rx_empty), .rx_fifo_dout(rx_fifo_dout),
      .tx_wen(tx_wen), .tx_fifo_din(tx_fifo_din), .rx_ren(rx_ren),
      .rx_rdata(rx_rdata), .tx_busy(tx_busy), .rx_valid(rx_valid),
      .tx_ovr(tx_ovr), .rx_udr(rx_udr), .ch_r(ch_r), .state(state)
   );

   task automatic model_reset();
      m_phase = 0; m_hold.delete(); m_odd = 0; m_inflight = 0; m_have = 0;
      m_rx_word = 32'h0; m_ovr = 0; m_udr = 0; m_turn = 0;
      e_wen = 0; e_ren = 0; e_din = 32'h0;
   endtask

   // One clock edge of the reference model, from the current inputs
   task automatic model_step();
      bit tx_can, pad_can, rx_can, tx_win, rx_win, busy_pre, odd_pre;
      bit ovr_set, udr_set;
      logic [31:0] head;
      if (soft_rst) begin
         model_reset();
         return;
      end
      busy_pre = (m_hold.size() != 0);
      odd_pre  = m_odd;
      head     = busy_pre ? m_hold[0] : 32'h0;
      tx_can   = (m_phase != 0) && busy_pre && !tx_full;
      pad_can  = (m_phase == 2) && !busy_pre && stereo && m_odd && !tx_full;
      rx_can   = (m_phase == 1) && (mode inside {2'b00, 2'b10}) && !m_have
                 && !m_inflight && !rx_empty;
      tx_win   = tx_can && (!rx_can || m_turn == 0);
      rx_win   = rx_can && !tx_win;
      if (tx_can && rx_can) m_turn = tx_win ? 1 : 0;

      udr_set = 0;
      if (m_phase != 0 && rx_req) begin
         if (m_have) m_have = 0;
         else        udr_set = 1;
      end
      if (m_inflight) begin
         m_have = 1;
         m_rx_word = rx_fifo_dout;
      end
      m_inflight = rx_win;
      e_ren = rx_win;

      e_wen = tx_win || pad_can;
      if (tx_win) begin
         e_din = mute ? 32'h0 : head;
         void'(m_hold.pop_front());
      end else if (pad_can) begin
         e_din = 32'h0;
      end
      if (e_wen && stereo) m_odd = !m_odd;

      ovr_set = 0;
      if (tx_req) begin
         if (m_phase == 1 && (mode inside {2'b01, 2'b11}) && m_hold.size() == 0)
            m_hold.push_back(tx_wdata);
         else if (m_phase != 0)
            ovr_set = 1;
      end
      if (ovr_set) m_ovr = 1; else if (flag_clr) m_ovr = 0;
      if (udr_set) m_udr = 1; else if (flag_clr) m_udr = 0;

      case (m_phase)
         0: if (!stop) m_phase = 1;
         1: if (stop) m_phase = 2;
         2: if (!busy_pre && !(stereo && odd_pre)) m_phase = 0;
         default: m_phase = 0;
      endcase
   endtask

   // Advance one clock; model and DUT see the same inputs
   task automatic tick();
      model_step();
      @(posedge pclk);
      #1;
   endtask

   task automatic quiet();
      tx_req = 0; rx_req = 0; flag_clr = 0; soft_rst = 0;
      tx_full = 0; rx_empty = 1; mute = 0; stereo = 0;
   endtask

   task automatic restart(input logic [1:0] md);
      quiet();
      soft_rst = 1; stop = 1;
      tick();
      soft_rst = 0; mode = md; stop = 0;
      tick();
   endtask

   task automatic test_reset();
      quiet(); rst_ = 0; stop = 1; mode = 2'b01; tx_wdata = 0; rx_fifo_dout = 0;
      model_reset();
      repeat (2) @(posedge pclk);
      #1;
      n_cmp++;
      if ({tx_wen, tx_fifo_din, rx_ren, rx_rdata, tx_busy, rx_valid, tx_ovr,
           rx_udr, ch_r, state} !== 71'h0) begin
         n_bad++; $display("FAIL reset_outputs: got nonzero outputs, state=%0d want all 0", state);
      end
      @(negedge pclk);
      rst_ = 1;
      tick();
      n_cmp++;
      if (state !== 2'b00) begin n_bad++; $display("FAIL reset_idle_hold: got %0d want 0", state); end
      stop = 0;
      tick();
      n_cmp++;
      if (state !== 2'b01) begin n_bad++; $display("FAIL idle_to_run: got %0d want 1", state); end
   endtask

   task automatic test_basic_tx();
      restart(2'b01);
      tx_wdata = 32'hA5A5_1234; tx_req = 1;
      tick();
      tx_req = 0;
      n_cmp++;
      if ({tx_busy, tx_wen} !== 2'b10) begin n_bad++; $display("FAIL basic_capture: busy/wen got %b want 10", {tx_busy, tx_wen}); end
      tick();
      n_cmp++;
      if ({tx_wen, tx_busy} !== 2'b10) begin n_bad++; $display("FAIL basic_push: wen/busy got %b want 10", {tx_wen, tx_busy}); end
      n_cmp++;
      if (tx_fifo_din !== 32'hA5A5_1234) begin n_bad++; $display("FAIL basic_data: got %h want a5a51234", tx_fifo_din); end
      tick();
      n_cmp++;
      if (tx_wen !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: got %b want 0", tx_wen); end
   endtask

   task automatic test_overrun_mute();
      restart(2'b11);
      tx_full = 1; tx_req = 1; tx_wdata = 32'h1111_1111;
      tick();
      tx_wdata = 32'h2222_2222;
      tick();
      tx_req = 0;
      n_cmp++;
      if ({tx_ovr, tx_busy, tx_wen} !== 3'b110) begin n_bad++; $display("FAIL ovr_set: ovr/busy/wen got %b want 110", {tx_ovr, tx_busy, tx_wen}); end
      mute = 1; tx_full = 0;
      tick();
      n_cmp++;
      if (tx_wen !== 1'b1 || tx_fifo_din !== 32'h0) begin n_bad++; $display("FAIL mute_push: wen=%b din=%h want 1/0", tx_wen, tx_fifo_din); end
      mute = 0; flag_clr = 1;
      tick();
      flag_clr = 0;
      n_cmp++;
      if (tx_ovr !== 1'b0) begin n_bad++; $display("FAIL flag_clr: got %b want 0", tx_ovr); end
   endtask

   task automatic test_rx_prefetch();
      restart(2'b00);
      rx_req = 1;
      tick();
      rx_req = 0;
      n_cmp++;
      if ({rx_udr, rx_valid} !== 2'b10) begin n_bad++; $display("FAIL rx_udr: udr/valid got %b want 10", {rx_udr, rx_valid}); end
      rx_fifo_dout = 32'hDEAD_BEEF; rx_empty = 0;
      tick();
      n_cmp++;
      if (rx_ren !== 1'b1) begin n_bad++; $display("FAIL rx_ren: got %b want 1", rx_ren); end
      rx_empty = 1;
      tick();
      n_cmp++;
      if ({rx_valid, rx_ren} !== 2'b10 || rx_rdata !== 32'hDEAD_BEEF) begin
         n_bad++; $display("FAIL rx_capture: valid/ren=%b rdata=%h want 10/deadbeef", {rx_valid, rx_ren}, rx_rdata);
      end
      rx_fifo_dout = 32'h0; rx_req = 1;
      tick();
      rx_req = 0;
      n_cmp++;
      if (rx_valid !== 1'b0 || rx_rdata !== 32'hDEAD_BEEF || rx_udr !== 1'b1) begin
         n_bad++; $display("FAIL rx_read: valid=%b rdata=%h udr=%b want 0/deadbeef/1", rx_valid, rx_rdata, rx_udr);
      end
   endtask

   task automatic test_arbitration();
      restart(2'b01);
      tx_full = 1; tx_wdata = 32'h0000_00A1; tx_req = 1;
      tick();
      tx_req = 0; mode = 2'b00; rx_empty = 0; tx_full = 0; rx_fifo_dout = 32'hC0DE_0001;
      tick();
      n_cmp++;
      if ({tx_wen, rx_ren} !== 2'b10) begin n_bad++; $display("FAIL arb_first_tx: got %b want 10", {tx_wen, rx_ren}); end
      tick();
      n_cmp++;
      if ({tx_wen, rx_ren} !== 2'b01) begin n_bad++; $display("FAIL arb_then_rx: got %b want 01", {tx_wen, rx_ren}); end
      tick();
      n_cmp++;
      if (rx_valid !== 1'b1 || rx_rdata !== 32'hC0DE_0001) begin n_bad++; $display("FAIL arb_capture: valid=%b rdata=%h want 1/c0de0001", rx_valid, rx_rdata); end
      rx_req = 1;
      tick();
      rx_req = 0; mode = 2'b01; tx_full = 1; tx_wdata = 32'h0000_00A2; tx_req = 1;
      tick();
      tx_req = 0; mode = 2'b00; tx_full = 0;
      tick();
      n_cmp++;
      if ({tx_wen, rx_ren} !== 2'b01) begin n_bad++; $display("FAIL arb_second_rx: got %b want 01", {tx_wen, rx_ren}); end
      tick();
      n_cmp++;
      if ({tx_wen, rx_ren} !== 2'b10 || tx_fifo_din !== 32'h0000_00A2) begin
         n_bad++; $display("FAIL arb_second_tx: wen/ren=%b din=%h want 10/000000a2", {tx_wen, rx_ren}, tx_fifo_din);
      end
   endtask

   task automatic test_stereo_pad();
      logic [31:0] w;
      restart(2'b01);
      stereo = 1;
      for (int i = 0; i < 3; i++) begin
         w = $urandom | 32'h1;
         tx_wdata = w; tx_req = 1;
         tick();
         tx_req = 0;
         tick();
         n_cmp++;
         if (tx_wen !== 1'b1 || tx_fifo_din !== w) begin n_bad++; $display("FAIL stereo_push%0d: wen=%b din=%h want 1/%h", i, tx_wen, tx_fifo_din, w); end
      end
      n_cmp++;
      if (ch_r !== 1'b1) begin n_bad++; $display("FAIL stereo_chr: got %b want 1", ch_r); end
      stop = 1;
      tick();
      n_cmp++;
      if (state !== 2'b10) begin n_bad++; $display("FAIL pad_drain: got %0d want 2", state); end
      tick();
      n_cmp++;
      if (tx_wen !== 1'b1 || tx_fifo_din !== 32'h0 || ch_r !== 1'b0) begin
         n_bad++; $display("FAIL pad_push: wen=%b din=%h ch_r=%b want 1/0/0", tx_wen, tx_fifo_din, ch_r);
      end
      tick();
      n_cmp++;
      if (state !== 2'b00) begin n_bad++; $display("FAIL pad_idle: got %0d want 0", state); end
      stop = 0; stereo = 0;
   endtask

   task automatic test_reset_mid();
      restart(2'b01);
      tx_full = 1; tx_req = 1; tx_wdata = 32'h5A5A_0F0F;
      tick();
      tx_req = 0; mode = 2'b00; rx_empty = 0;
      tick();
      n_cmp++;
      if ({rx_ren, tx_busy} !== 2'b11) begin n_bad++; $display("FAIL mid_setup: ren/busy got %b want 11", {rx_ren, tx_busy}); end
      soft_rst = 1;
      tick();
      soft_rst = 0;
      n_cmp++;
      if ({tx_wen, tx_fifo_din, rx_ren, rx_rdata, tx_busy, rx_valid, tx_ovr,
           rx_udr, ch_r, state} !== 71'h0) begin
         n_bad++; $display("FAIL soft_rst_outputs: busy=%b ren=%b valid=%b state=%0d want all 0", tx_busy, rx_ren, rx_valid, state);
      end
      mode = 2'b01; rx_empty = 1;
      tick();
      tx_req = 1;
      tick();
      tx_req = 0; mode = 2'b00; rx_empty = 0;
      tick();
      #2 rst_ = 0;
      #1;
      n_cmp++;
      if ({tx_wen, tx_fifo_din, rx_ren, rx_rdata, tx_busy, rx_valid, tx_ovr,
           rx_udr, ch_r, state} !== 71'h0) begin
         n_bad++; $display("FAIL async_rst_outputs: busy=%b ren=%b state=%0d want all 0", tx_busy, rx_ren, state);
      end
      #1 rst_ = 1;
      model_reset();
      quiet();
      tick();
      n_cmp++;
      if (state !== 2'b01) begin n_bad++; $display("FAIL after_rst_run: got %0d want 1", state); end
   endtask

   task automatic test_random();
      logic [8:0] got, exp;
      restart(2'b01);
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) stop = ~stop;
         if ($urandom_range(0, 63) == 0) stereo = ~stereo;
         mute         = ($urandom_range(0, 3) == 0);
         soft_rst     = ($urandom_range(0, 199) == 0);
         flag_clr     = ($urandom_range(0, 19) == 0);
         tx_req       = ($urandom_range(0, 2) == 0);
         rx_req       = ($urandom_range(0, 3) == 0);
         tx_full      = ($urandom_range(0, 2) == 0);
         rx_empty     = ($urandom_range(0, 2) == 0);
         tx_wdata     = $urandom;
         rx_fifo_dout = $urandom;
         tick();
         got = {state, tx_busy, rx_valid, tx_ovr, rx_udr, ch_r, tx_wen, rx_ren};
         exp = {m_phase[1:0], (m_hold.size() != 0), m_have, m_ovr, m_udr, m_odd, e_wen, e_ren};
         n_cmp++;
         if (got !== exp) begin n_bad++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, got, exp); end
         n_cmp++;
         if (rx_rdata !== m_rx_word) begin n_bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, rx_rdata, m_rx_word); end
         if (e_wen) begin
            n_cmp++;
            if (tx_fifo_din !== e_din) begin n_bad++; $display("FAIL rand_din[%0d]: got %h want %h", i, tx_fifo_din, e_din); end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_tx();
      test_overrun_mute();
      test_rx_prefetch();
      test_arbitration();
      test_stereo_pad();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2s_xfer_sched.md
# i2s_xfer_sched

Transfer scheduler between the APB register side and the I2S Tx/Rx FIFOs, running entirely in the pclk domain. It holds one Tx word and one Rx word, and sequences FIFO pushes and pops under the control fields. It pads incomplete stereo frames on stop and forces mute zeros. It grants the single per-cycle FIFO access slot between Tx push and Rx pop round-robin.

## Interface
- No parameters; data width is fixed at 32 bits.
- pclk  in  1  system/APB clock; all state is on its rising edge.
- rst_  in  1  asynchronous active-low reset.
- mode  in  2  operating mode: SR=00, ST=01, MR=10, MT=11. Tx path enabled for ST/MT, Rx path for SR/MR.
- stop  in  1  level; request orderly stop.
- mute  in  1  level; replace pushed Tx data with 0.
- stereo  in  1  level; 1 = L/R pairing enforced.
- soft_rst  in  1  level; synchronous clear of all scheduler state.
- flag_clr  in  1  pulse; clears sticky flags.
- tx_req  in  1  pulse; APB write to the Tx data register.
- tx_wdata  in  32  data qualified by tx_req.
- rx_req  in  1  pulse; APB read of the Rx data register.
- tx_full  in  1  Tx FIFO full.
- rx_empty  in  1  Rx FIFO empty.
- rx_fifo_dout  in  32  Rx FIFO read data, valid one cycle after rx_ren.
- tx_wen  out  1  Tx FIFO write strobe.
- tx_fifo_din  out  32  Tx FIFO write data.
- rx_ren  out  1  Rx FIFO read strobe.
- rx_rdata  out  32  Rx holding register.
- tx_busy  out  1  Tx holding register occupied.
- rx_valid  out  1  Rx holding register holds unread data.
- tx_ovr  out  1  sticky: tx_req dropped.
- rx_udr  out  1  sticky: rx_req with no data.
- ch_r  out  1  next Tx push is the right channel (stereo).
- state  out  2  IDLE=00, RUN=01, DRAIN=10.

## Operation
- All outputs reset to 0 on rst_ low. The FSM resets to IDLE and the round-robin pointer to Tx-first.
- soft_rst=1 has the same effect as reset on the next edge. It takes precedence over every other event.
- IDLE: tx_req and rx_req are ignored and no flags are set. No FIFO access. Moves to RUN when stop=0.
- RUN: moves to DRAIN when stop=1.
- tx_req acceptance:
  - Accepted only in RUN, with a Tx-mode, and when tx_busy=0. The word is captured into the hold register and tx_busy is set.
  - tx_req while tx_busy=1, or in a non-Tx mode while in RUN, is dropped and sets tx_ovr.
- Tx push eligibility: tx_busy=1 and tx_full=0.
  - On grant: tx_wen=1, tx_fifo_din = mute ? 0 : hold, tx_busy cleared, and ch_r toggles when stereo=1.
- Rx prefetch eligibility: RUN, Rx-mode, rx_valid=0, no read in flight, rx_empty=0.
  - On grant: rx_ren=1. The next cycle captures rx_fifo_dout into rx_rdata and sets rx_valid.
- rx_req handling:
  - With rx_valid=1: rx_valid clears on that edge, and rx_rdata is held until the next capture.
  - With rx_valid=0: sets rx_udr and rx_rdata is unchanged.
- Arbitration: at most one of tx_wen and rx_ren per cycle.
  - If both are eligible, grant the side not granted last. The pointer updates only on contested grants.
- DRAIN sequence:
  - New tx_req sets tx_ovr; no Rx prefetch is started.
  - First push any pending Tx hold.
  - Then, if stereo=1 and ch_r=1, push one 0 word (pad) when tx_full=0, which clears ch_r.
  - Then go to IDLE. An in-flight Rx read still completes its capture.
- Deasserting stop during DRAIN has no effect until IDLE is reached.
- flag_clr clears tx_ovr and rx_udr. A set event in the same cycle wins.
- tx_req and a push in the same cycle when tx_busy=1: the push clears the old word and the new word is accepted (no ovr).

## Timing
- tx_req to tx_wen: 1 cycle minimum, stalled while tx_full=1 or arbitration is lost.
- rx_ren to rx_valid: 1 cycle. rx_valid to rx_req acceptance: same edge.
- Sustained throughput is one FIFO operation per cycle; contested Tx and Rx each get one grant every 2 cycles.
- tx_wen and rx_ren are single-cycle pulses, registered with no combinational path from inputs.

## Test plan
- Basic Tx: mode=ST, RUN, tx_req with 0xA5A5_1234 -> tx_wen high 1 cycle later with tx_fifo_din=0xA5A5_1234, tx_busy back to 0.
- Overrun and mute: tx_req twice on consecutive cycles with tx_full=1 -> second word dropped and tx_ovr=1. Then mute=1 and release tx_full -> pushed data 0. flag_clr -> tx_ovr=0.
- Rx prefetch: mode=SR, rx_empty=0, rx_fifo_dout=0xDEAD_BEEF -> rx_ren, then rx_valid=1 and rx_rdata=0xDEAD_BEEF. An rx_req with rx_valid=0 beforehand -> rx_udr=1.
- Arbitration: mode value with both paths eligible every cycle (force via held tx_busy and rx_empty=0) -> grants alternate Tx, Rx, Tx, starting with Tx after reset.
- Stereo pad: stereo=1, push 3 words, then stop=1 -> fourth push is 0x0, ch_r=0, and state goes DRAIN to IDLE.
- Reset mid-operation: soft_rst with tx_busy=1 and a read in flight -> next cycle all outputs 0 and state=IDLE. Asserting rst_ low asynchronously does the same immediately.
